// File: rtl/pc_gen_unit_if.sv
// Fetch-PC generator bundle: control/redirect/RAS inputs and PC/status outputs.
`timescale 1ns/1ps
interface pc_gen_unit_if #(
  parameter int XLEN = 32
);
  logic            en;
  logic            stall;
  logic            trap_req;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            ras_push;
  logic [XLEN-1:0] ras_push_addr;
  logic            ras_pop;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            flush_out;
  logic            redirect_pend;
  logic            misalign_err;
  logic            ras_empty;

  modport master (
    output en, stall, trap_req, redirect_valid, redirect_addr,
           ras_push, ras_push_addr, ras_pop,
    input  pc, pc_plus, flush_out, redirect_pend, misalign_err, ras_empty
  );

  modport slave (
    input  en, stall, trap_req, redirect_valid, redirect_addr,
           ras_push, ras_push_addr, ras_pop,
    output pc, pc_plus, flush_out, redirect_pend, misalign_err, ras_empty
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: trap > redirect > deferred redirect > RAS pop > PC+INSTR_BYTES.
// Optional return-address stack is built when PC_RAS_EN is defined.
`timescale 1ns/1ps
module pc_gen_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  pc_gen_unit_if.slave bus
);

  localparam logic [XLEN-1:0] INCR       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] pend_addr_reg, pend_addr_next;
  logic            pend_valid_reg, pend_valid_next;
  logic            pend_trap_reg, pend_trap_next;
  logic            flush_reg, flush_next;
  logic            misalign_reg, misalign_next;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] target;
  logic            load_target;
  logic            advance;
  logic            ras_pop_hit;
  logic [XLEN-1:0] ras_top_val;

  assign advance = bus.en & ~bus.stall;
  assign pc_plus = pc_reg + INCR;

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_top_reg, ras_top_next, ras_wr_ptr;
  logic [CNT_W-1:0] ras_cnt_reg, ras_cnt_next;
  logic             ras_nonempty, ras_do_pop, ras_do_push, ras_we;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - 1'b1;
  endfunction

  assign ras_nonempty = (ras_cnt_reg != '0);
  assign ras_top_val  = ras_mem[ras_top_reg];
  assign ras_pop_hit  = advance & bus.ras_pop & ras_nonempty;
  // A live trap/redirect means the popped return was on a squashed path.
  assign ras_do_pop   = ras_pop_hit & ~bus.trap_req & ~bus.redirect_valid;
  assign ras_do_push  = advance & bus.ras_push;

  always_comb begin
    ras_top_next = ras_top_reg;
    ras_cnt_next = ras_cnt_reg;
    ras_wr_ptr   = ras_top_reg;
    ras_we       = 1'b0;
    if (ras_do_push && ras_do_pop) begin
      ras_we = 1'b1;
    end else if (ras_do_push) begin
      ras_wr_ptr   = ptr_inc(ras_top_reg);
      ras_we       = 1'b1;
      ras_top_next = ras_wr_ptr;
      if (ras_cnt_reg != CNT_W'(RAS_DEPTH)) begin
        ras_cnt_next = ras_cnt_reg + 1'b1;
      end
    end else if (ras_do_pop) begin
      ras_top_next = ptr_dec(ras_top_reg);
      ras_cnt_next = ras_cnt_reg - 1'b1;
    end
  end

  always_ff @(negedge clock) begin
    if (ras_we) begin
      ras_mem[ras_wr_ptr] <= bus.ras_push_addr;
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ras_top_reg <= PTR_W'(RAS_DEPTH - 1);
      ras_cnt_reg <= '0;
    end else begin
      ras_top_reg <= ras_top_next;
      ras_cnt_reg <= ras_cnt_next;
    end
  end

  assign bus.ras_empty = ~ras_nonempty;
`else
  logic ras_unused;
  assign ras_unused    = ^{bus.ras_push, bus.ras_pop, bus.ras_push_addr};
  assign ras_pop_hit   = 1'b0;
  assign ras_top_val   = '0;
  assign bus.ras_empty = 1'b1;
`endif

  always_comb begin
    pc_next         = pc_reg;
    pend_valid_next = pend_valid_reg;
    pend_trap_next  = pend_trap_reg;
    pend_addr_next  = pend_addr_reg;
    flush_next      = 1'b0;
    misalign_next   = 1'b0;
    target          = pc_plus;
    load_target     = 1'b0;
    if (advance) begin
      pend_valid_next = 1'b0;
      pend_trap_next  = 1'b0;
      if (bus.trap_req) begin
        target      = TRAP_VECTOR;
        load_target = 1'b1;
      end else if (bus.redirect_valid) begin
        target      = bus.redirect_addr;
        load_target = 1'b1;
      end else if (pend_valid_reg) begin
        target      = pend_addr_reg;
        load_target = 1'b1;
      end else if (ras_pop_hit) begin
        target      = ras_top_val;
        load_target = 1'b1;
      end
      if (load_target) begin
        pc_next       = target & ~ALIGN_MASK;
        flush_next    = 1'b1;
        misalign_next = |(target & ALIGN_MASK);
      end else begin
        pc_next = pc_plus;
      end
    end else if (bus.trap_req) begin
      pend_valid_next = 1'b1;
      pend_trap_next  = 1'b1;
      pend_addr_next  = TRAP_VECTOR;
    end else if (bus.redirect_valid && !(pend_valid_reg && pend_trap_reg)) begin
      // A deferred trap must never be displaced by a later branch.
      pend_valid_next = 1'b1;
      pend_trap_next  = 1'b0;
      pend_addr_next  = bus.redirect_addr;
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg         <= RESET_VECTOR;
      pend_valid_reg <= 1'b0;
      pend_trap_reg  <= 1'b0;
      pend_addr_reg  <= '0;
      flush_reg      <= 1'b0;
      misalign_reg   <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      pend_valid_reg <= pend_valid_next;
      pend_trap_reg  <= pend_trap_next;
      pend_addr_reg  <= pend_addr_next;
      flush_reg      <= flush_next;
      misalign_reg   <= misalign_next;
    end
  end

  assign bus.pc            = pc_reg;
  assign bus.pc_plus       = pc_plus;
  assign bus.flush_out     = flush_reg;
  assign bus.redirect_pend = pend_valid_reg;
  assign bus.misalign_err  = misalign_reg;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed vectors, queue-based reference model, per-cycle compare.
`timescale 1ns/1ps
module tb_pc_gen_unit;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;
  localparam int          IB    = 4;
  localparam int          DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  pc_gen_unit_if #(.XLEN(XLEN)) bus ();

  pc_gen_unit #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV),
    .INSTR_BYTES(IB), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  int n_cyc = 0;

  logic [31:0] m_pc;
  logic [31:0] m_pend_addr;
  bit          m_pend_v, m_pend_trap, m_flush, m_mis;
  logic [31:0] m_ras[$];
  bit          m_check = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc = RV; m_pend_v = 0; m_pend_trap = 0; m_pend_addr = '0;
    m_flush = 0; m_mis = 0;
    m_ras.delete();
  endfunction

  // Reference: what the next PC and flags must be given the inputs held this cycle.
  function automatic void model_step();
    logic [31:0] tgt;
    bit nonseq, popped;
    if (!(bus.en && !bus.stall)) begin
      m_flush = 0; m_mis = 0;
      if (bus.trap_req) begin
        m_pend_v = 1; m_pend_trap = 1; m_pend_addr = TV;
      end else if (bus.redirect_valid && !(m_pend_v && m_pend_trap)) begin
        m_pend_v = 1; m_pend_trap = 0; m_pend_addr = bus.redirect_addr;
      end
      return;
    end
    nonseq = 1; tgt = '0;
    if (bus.trap_req) tgt = TV;
    else if (bus.redirect_valid) tgt = bus.redirect_addr;
    else if (m_pend_v) tgt = m_pend_addr;
    else if (RAS_ON && bus.ras_pop && m_ras.size() > 0) tgt = m_ras[$];
    else nonseq = 0;
    if (RAS_ON) begin
      popped = bus.ras_pop && m_ras.size() > 0 && !bus.trap_req && !bus.redirect_valid;
      if (bus.ras_push && popped) m_ras[$] = bus.ras_push_addr;
      else begin
        if (popped) void'(m_ras.pop_back());
        if (bus.ras_push) begin
          m_ras.push_back(bus.ras_push_addr);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
    end
    m_pend_v = 0; m_pend_trap = 0;
    m_flush = nonseq;
    m_mis = nonseq && (tgt % IB) != 0;
    m_pc = nonseq ? tgt - (tgt % IB) : m_pc + IB;
  endfunction

  always @(posedge clock) begin
    if (m_check) begin
      chk("cyc_pc", bus.pc, m_pc);
      chk("cyc_pc_plus", bus.pc_plus, m_pc + IB);
      chk("cyc_flush", 32'(bus.flush_out), 32'(m_flush));
      chk("cyc_pend", 32'(bus.redirect_pend), 32'(m_pend_v));
      chk("cyc_misalign", 32'(bus.misalign_err), 32'(m_mis));
      chk("cyc_ras_empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
    end
  end

  task automatic drive(input bit en, input bit st, input bit tr, input bit rv,
                       input logic [31:0] ra, input bit pu = 0,
                       input logic [31:0] pa = '0, input bit po = 0);
    bus.en = en; bus.stall = st; bus.trap_req = tr; bus.redirect_valid = rv;
    bus.redirect_addr = ra; bus.ras_push = pu; bus.ras_push_addr = pa; bus.ras_pop = po;
    @(negedge clock);
    #1;
    model_step();
    n_cyc++;
    $display("cyc %0d en=%0b st=%0b tr=%0b rv=%0b ra=0x%08h pu=%0b po=%0b -> pc=0x%08h fl=%0b pend=%0b mis=%0b",
             n_cyc, en, st, tr, rv, ra, pu, po, bus.pc, bus.flush_out, bus.redirect_pend, bus.misalign_err);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, bus.pc, RV);
    chk({tag, "_flush"}, 32'(bus.flush_out), 32'd0);
    chk({tag, "_pend"}, 32'(bus.redirect_pend), 32'd0);
    chk({tag, "_mis"}, 32'(bus.misalign_err), 32'd0);
    chk({tag, "_ras_empty"}, 32'(bus.ras_empty), 32'd1);
  endtask

  initial begin
    bus.en = 0; bus.stall = 0; bus.trap_req = 0; bus.redirect_valid = 0;
    bus.redirect_addr = '0; bus.ras_push = 0; bus.ras_push_addr = '0; bus.ras_pop = 0;
    model_reset();
    m_check = 1'b1;
    #2;
    chk_reset_state("init");
    @(negedge clock);
    #1 reset_n = 1'b1;

    // Free-run from reset vector.
    drive(1, 0, 0, 0, '0); chk("run_pc1", bus.pc, 32'h4); chk("run_fl1", 32'(bus.flush_out), 0);
    drive(1, 0, 0, 0, '0); chk("run_pc2", bus.pc, 32'h8);
    drive(1, 0, 0, 0, '0); chk("run_pc3", bus.pc, 32'hC); chk("run_fl3", 32'(bus.flush_out), 0);

    // Mid-run reset from pc=0x40 with a flush pulse live.
    drive(1, 0, 0, 1, 32'h40); chk("pre_rst_pc", bus.pc, 32'h40);
    #1 reset_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    model_reset();
    #1 reset_n = 1'b1;

    // Redirect during stall is deferred, then applied on release.
    drive(1, 1, 0, 1, 32'h200); chk("st_pc", bus.pc, RV); chk("st_pend", 32'(bus.redirect_pend), 1);
    drive(1, 1, 0, 0, '0);
    drive(1, 1, 0, 0, '0); chk("st_pc2", bus.pc, RV); chk("st_pend2", 32'(bus.redirect_pend), 1);
    drive(1, 0, 0, 0, '0); chk("rel_pc", bus.pc, 32'h200); chk("rel_fl", 32'(bus.flush_out), 1);
    chk("rel_pend", 32'(bus.redirect_pend), 0);
    drive(1, 0, 0, 0, '0); chk("post_pc", bus.pc, 32'h204); chk("post_fl", 32'(bus.flush_out), 0);
    drive(0, 0, 0, 0, '0); chk("en0_pc", bus.pc, 32'h204);

    // Deferred trap outranks earlier and later deferred branches.
    drive(1, 1, 0, 1, 32'h200);
    drive(1, 1, 1, 0, '0);
    drive(1, 1, 0, 1, 32'h600); chk("trp_pend", 32'(bus.redirect_pend), 1);
    drive(1, 0, 0, 0, '0); chk("trp_pc", bus.pc, TV); chk("trp_fl", 32'(bus.flush_out), 1);
    drive(1, 0, 0, 0, '0); chk("trp_seq", bus.pc, 32'h104);
    drive(1, 0, 1, 1, 32'h500); chk("trp_vs_rv", bus.pc, TV);
    // A live redirect outranks a deferred one on the release edge.
    drive(1, 1, 0, 1, 32'h700);
    drive(1, 0, 0, 1, 32'h800); chk("live_vs_pend", bus.pc, 32'h800);

    // Misaligned target and wraparound.
    drive(1, 0, 0, 1, 32'h303); chk("mis_pc", bus.pc, 32'h300);
    chk("mis_err", 32'(bus.misalign_err), 1); chk("mis_fl", 32'(bus.flush_out), 1);
    drive(1, 0, 0, 0, '0); chk("mis_clr", 32'(bus.misalign_err), 0); chk("mis_pc2", bus.pc, 32'h304);
    drive(1, 0, 0, 1, 32'hFFFF_FFFC); chk("wrap_pre", bus.pc, 32'hFFFF_FFFC);
    chk("wrap_plus", bus.pc_plus, 32'h0);
    drive(1, 0, 0, 0, '0); chk("wrap_pc", bus.pc, 32'h0); chk("wrap_fl", 32'(bus.flush_out), 0);

`ifdef PC_RAS_EN
    // Overfilled stack drops oldest; pops return newest first.
    for (int i = 1; i <= 5; i++) drive(1, 0, 0, 0, '0, 1, 32'(i * 16));
    chk("ras_full", 32'(bus.ras_empty), 0);
    drive(1, 0, 0, 0, '0, 0, '0, 1); chk("pop1", bus.pc, 32'h50);
    drive(1, 0, 0, 0, '0, 0, '0, 1); chk("pop2", bus.pc, 32'h40);
    drive(1, 0, 0, 0, '0, 0, '0, 1); chk("pop3", bus.pc, 32'h30);
    drive(1, 0, 0, 0, '0, 0, '0, 1); chk("pop4", bus.pc, 32'h20);
    chk("pop4_empty", 32'(bus.ras_empty), 1);
    drive(1, 0, 0, 0, '0, 0, '0, 1); chk("pop5_seq", bus.pc, 32'h24);
    chk("pop5_fl", 32'(bus.flush_out), 0);
    drive(1, 0, 0, 0, '0, 1, 32'h10);
    drive(1, 0, 0, 0, '0, 1, 32'h90, 1); chk("pushpop_pc", bus.pc, 32'h10);
    drive(1, 0, 0, 0, '0, 0, '0, 1); chk("pushpop_top", bus.pc, 32'h90);
    drive(1, 0, 0, 0, '0, 1, 32'hA0);
    drive(1, 0, 1, 0, '0, 0, '0, 1); chk("trap_pop_pc", bus.pc, TV);
    chk("trap_pop_keep", 32'(bus.ras_empty), 0);
    drive(1, 0, 0, 0, '0, 0, '0, 1); chk("trap_pop_top", bus.pc, 32'hA0);
`else
    drive(1, 0, 0, 0, '0, 1, 32'h10, 1); chk("noras_seq", bus.pc, 32'h4);
    chk("noras_empty", 32'(bus.ras_empty), 1); chk("noras_fl", 32'(bus.flush_out), 0);
`endif

    @(posedge clock);
    #1;
    m_check = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
